// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single layout, canonical constants and flag vector.
package fpu_pkg;

  localparam int unsigned FLAG_W         = 4;
  localparam int unsigned FLAG_INVALID   = 0;
  localparam int unsigned FLAG_OVERFLOW  = 1;
  localparam int unsigned FLAG_UNDERFLOW = 2;
  localparam int unsigned FLAG_ZERO      = 3;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef logic [FLAG_W-1:0] fp_flags_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/fp_operand_classify.sv
// Classifies one single-precision operand; denormals are flushed and reported as zero.
module fp_operand_classify
  import fpu_pkg::*;
(
  input  logic [31:0] operand,
  input  logic        negate,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero,
  output logic        sign
);

  fp32_t v;

  assign v       = fp32_t'(operand);
  assign is_nan  = (v.exp == EXP_MAX) && (v.man != '0);
  assign is_inf  = (v.exp == EXP_MAX) && (v.man == '0);
  assign is_zero = (v.exp == '0);
  assign sign    = v.sign ^ negate;

endmodule

// File: rtl/fp_addsub_result_stage.sv
// Registered correction stage behind an FP add/sub datapath: fixes special cases,
// detects exponent wrap, and keeps sticky flags plus a transfer counter.
module fp_addsub_result_stage
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_raw,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags,
  output logic [3:0]  sticky_flags,
  input  logic        flags_clr,
  output logic [15:0] result_count
);

  logic a_nan, a_inf, a_zero, a_sign;
  logic b_nan, b_inf, b_zero, b_sign;

  fp_operand_classify u_class_a (
    .operand (in_a),
    .negate  (1'b0),
    .is_nan  (a_nan),
    .is_inf  (a_inf),
    .is_zero (a_zero),
    .sign    (a_sign)
  );

  fp_operand_classify u_class_b (
    .operand (in_b),
    .negate  (in_op),
    .is_nan  (b_nan),
    .is_inf  (b_inf),
    .is_zero (b_zero),
    .sign    (b_sign)
  );

  fp32_t            a, b, raw, res;
  fp_flags_t        flags;
  logic [EXP_W-1:0] max_exp;
  logic             same_sign;
  logic             accept, xfer;

  assign a         = fp32_t'(in_a);
  assign b         = fp32_t'(in_b);
  assign raw       = fp32_t'(in_raw);
  assign max_exp   = (a.exp > b.exp) ? a.exp : b.exp;
  assign same_sign = (a_sign == b_sign);

  assign in_ready = rst_n && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // Result correction in priority order; the zero flag is derived from whatever wins.
  always_comb begin
    res   = raw;
    flags = '0;
    if (a_nan || b_nan) begin
      res                 = fp32_t'(QNAN);
      flags[FLAG_INVALID] = 1'b1;
    end else if (a_inf && b_inf && !same_sign) begin
      res                 = fp32_t'(QNAN);
      flags[FLAG_INVALID] = 1'b1;
    end else if (a_inf) begin
      res = '{sign: a_sign, exp: EXP_MAX, man: '0};
    end else if (b_inf) begin
      res = '{sign: b_sign, exp: EXP_MAX, man: '0};
    end else if (a_zero && b_zero) begin
      res = '{sign: a_sign & b_sign, exp: '0, man: '0};
    end else if (a_zero) begin
      res = '{sign: b_sign, exp: b.exp, man: b.man};
    end else if (b_zero) begin
      res = '{sign: a_sign, exp: a.exp, man: a.man};
    end else if ((raw.exp == EXP_MAX) || (same_sign && (raw.exp < max_exp))) begin
      res                  = '{sign: same_sign ? a_sign : raw.sign, exp: EXP_MAX, man: '0};
      flags[FLAG_OVERFLOW] = 1'b1;
    end else if (((raw.exp == '0) && (raw.man != '0)) || (!same_sign && (raw.exp > max_exp))) begin
      res                   = '{sign: raw.sign, exp: '0, man: '0};
      flags[FLAG_UNDERFLOW] = 1'b1;
    end
    flags[FLAG_ZERO] = ({res.exp, res.man} == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_flags    <= '0;
      sticky_flags <= '0;
      result_count <= '0;
    end else begin
      if (accept) begin
        out_valid  <= 1'b1;
        out_result <= 32'(res);
        out_flags  <= flags;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      // A clear coinciding with a transfer keeps the flags of that transfer.
      if (xfer) begin
        result_count <= result_count + 16'd1;
        sticky_flags <= flags_clr ? out_flags : (sticky_flags | out_flags);
      end else if (flags_clr) begin
        sticky_flags <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_result_stage.sv
// Directed bench for fp_addsub_result_stage with an expected-result queue.
module tb_fp_addsub_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_raw;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [3:0]  sticky_flags;
  logic        flags_clr;
  logic [15:0] result_count;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [15:0] exp_count = '0;

  always #5 clk = ~clk;

  fp_addsub_result_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_raw       (in_raw),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .flags_clr    (flags_clr),
    .result_count (result_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    assert (got === want) passed = passed + 1;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [31:0] raw, input logic [31:0] er, input logic [3:0] ef);
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_raw   = raw;
    in_valid = 1'b1;
    sb_q.push_back({er, ef});
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      total = total + 1;
      $error("FAIL %s: got output with empty queue expected a queued result", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, out_result, e.res);
    chk({tag, "_flags"}, 32'(out_flags), 32'(e.flags));
    exp_count = exp_count + 16'd1;
  endtask

  // Offer one vector with out_ready high and check it one cycle after acceptance.
  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] raw,
                         input logic [31:0] er, input logic [3:0] ef);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    offer(a, b, op, raw, er, ef);
    @(negedge clk);
    in_valid = 1'b0;
    pop_check(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_raw    = '0;
    out_ready = 1'b1;
    flags_clr = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    chk("rst_count", 32'(result_count), 32'd0);
    rst_n = 1'b1;

    run_vec("add_1_1",    32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 32'h40000000, 4'h0);
    run_vec("nan_a",      32'h7FC00001, 32'h3F800000, 1'b0, 32'h12345678, 32'h7FC00000, 4'h1);
    @(negedge clk);
    chk("sticky_nan", 32'(sticky_flags), 32'h1);
    chk("count_2", 32'(result_count), 32'(exp_count));

    run_vec("inf_sub",    32'h7F800000, 32'h7F800000, 1'b1, 32'h00000000, 32'h7FC00000, 4'h1);
    run_vec("inf_add",    32'h7F800000, 32'h7F800000, 1'b0, 32'h00000000, 32'h7F800000, 4'h0);
    run_vec("ovf_wrap",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h007FFFFF, 32'h7F800000, 4'h2);
    run_vec("ovf_raw_ff", 32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 32'h7F800000, 4'h2);
    run_vec("inf_b_eff",  32'h3F800000, 32'hFF800000, 1'b1, 32'h00000000, 32'h7F800000, 4'h0);
    run_vec("inf_a_neg",  32'hFF800000, 32'h00000000, 1'b0, 32'h00000000, 32'hFF800000, 4'h0);
    run_vec("zero_a",     32'h00000000, 32'h40400000, 1'b1, 32'h00000000, 32'hC0400000, 4'h0);
    run_vec("zero_b_ftz", 32'h40400000, 32'h00012345, 1'b0, 32'h00000000, 32'h40400000, 4'h0);
    run_vec("zeros_neg",  32'h80000000, 32'h00000000, 1'b1, 32'h00000000, 32'h80000000, 4'h8);
    run_vec("zeros_pos",  32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 32'h00000000, 4'h8);
    run_vec("unf_denorm", 32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 32'h00000000, 4'hC);
    run_vec("unf_borrow", 32'h3F800000, 32'h3F800001, 1'b1, 32'hFF000000, 32'h80000000, 4'hC);
    run_vec("pass_sub",   32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 32'h3F800000, 4'h0);
    run_vec("pass_zero",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 32'h00000000, 4'h8);
    @(negedge clk);
    chk("sticky_all", 32'(sticky_flags), 32'hF);
    chk("count_16", 32'(result_count), 32'(exp_count));

    // Clear with no transfer in flight empties the sticky flags.
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    chk("sticky_clr_idle", 32'(sticky_flags), 32'h0);

    // Backpressure: out_ready low across three edges while two results are offered.
    out_ready = 1'b0;
    offer(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 32'h40800000, 4'h0);
    @(negedge clk);
    chk("stall_in_ready_1", 32'(in_ready), 32'd0);
    chk("stall_valid_1", 32'(out_valid), 32'd1);
    offer(32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 32'h40400000, 4'h0);
    @(negedge clk);
    chk("stall_hold_result", out_result, 32'h40800000);
    chk("stall_in_ready_2", 32'(in_ready), 32'd0);
    @(negedge clk);
    pop_check("stall_v1");
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    pop_check("stall_v2");
    @(negedge clk);
    chk("stall_count", 32'(result_count), 32'(exp_count));
    chk("stall_drained", 32'(out_valid), 32'd0);

    // Sticky with a clear coinciding with an invalid transfer: new flags win.
    run_vec("nan_b", 32'h3F800000, 32'h7F800001, 1'b0, 32'h00000000, 32'h7FC00000, 4'h1);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    chk("sticky_clr_xfer", 32'(sticky_flags), 32'h1);

    // Reset while a result is held by backpressure.
    out_ready = 1'b0;
    offer(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 32'h40000000, 4'h0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst_valid_before", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", out_result, 32'd0);
    chk("midrst_flags", 32'(out_flags), 32'd0);
    chk("midrst_sticky", 32'(sticky_flags), 32'd0);
    chk("midrst_count", 32'(result_count), 32'd0);
    sb_q.delete();
    exp_count = '0;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    run_vec("post_rst", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 32'h40800000, 4'h0);
    @(negedge clk);
    chk("post_rst_count", 32'(result_count), 32'(exp_count));
    chk("queue_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
